// File: rtl/mx_block_quantizer_if.sv
// Handshake bundle between the MAC accumulator output, the MX block quantizer and write-back.
// master = upstream/downstream environment, slave = the quantizer.
interface mx_block_quantizer_if #(
    parameter int M_IN_WIDTH = 23,
    parameter int BLOCK_SIZE = 32
);
    localparam int IDX_W = $clog2(BLOCK_SIZE);

    logic                  in_valid;
    logic                  in_ready;
    logic [M_IN_WIDTH-1:0] in_mant;
    logic [7:0]            in_exp;
    logic                  in_sign;
    logic [1:0]            prec_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_elem;
    logic [7:0]            out_shared_exp;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_last;

    modport master (
        output in_valid, in_mant, in_exp, in_sign, prec_mode, out_ready,
        input  in_ready, out_valid, out_elem, out_shared_exp, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_mant, in_exp, in_sign, prec_mode, out_ready,
        output in_ready, out_valid, out_elem, out_shared_exp, out_idx, out_last
    );
endinterface

// File: rtl/mx_block_quantizer.sv
// Collects BLOCK_SIZE scalar FP results, derives a shared exponent and streams MX integer elements.
// Build option: define MX_QUANT_RNE_EN for round-to-nearest-even; otherwise magnitudes truncate.
module mx_block_quantizer #(
    parameter int M_IN_WIDTH = 23,
    parameter int BLOCK_SIZE = 32
) (
    input logic                clk_i,
    input logic                rstn,
    mx_block_quantizer_if.slave bus
);
    localparam int IDX_W  = $clog2(BLOCK_SIZE);
    localparam int LZ_W   = $clog2(M_IN_WIDTH + 1);
    localparam int WORD_W = M_IN_WIDTH + 12;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    typedef enum logic {FILL, EMIT} state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [IDX_W-1:0]        rd_addr;
    logic                    alive_reg;
    logic [1:0]              prec_reg;
    logic signed [9:0]       max_reg;
    logic                    any_nz_reg;
    logic [7:0]              shared_reg;
    logic [WORD_W-1:0]       rd_data_reg;
    logic [WORD_W-1:0]       mem [BLOCK_SIZE];

    function automatic logic [LZ_W-1:0] count_lz(input logic [M_IN_WIDTH-1:0] v);
        count_lz = LZ_W'(M_IN_WIDTH);
        for (int i = 0; i < M_IN_WIDTH; i++)
            if (v[i]) count_lz = LZ_W'(M_IN_WIDTH - 1 - i);
    endfunction

    // Ingest: normalise the mantissa and fold the exponent adjustment into e.
    logic [LZ_W-1:0]         lz;
    logic [M_IN_WIDTH-1:0]   in_nm;
    logic signed [9:0]       in_e;
    logic                    in_nz, in_fire, out_fire, first_elem;
    logic                    cur_any, blk_any, take_max;
    logic signed [9:0]       blk_max;
    logic [7:0]              shared_calc;

    always_comb begin
        lz         = count_lz(bus.in_mant);
        in_nm      = bus.in_mant << lz;
        in_e       = $signed({2'b00, bus.in_exp}) - $signed({{(10-LZ_W){1'b0}}, lz});
        in_nz      = |bus.in_mant;
        in_fire    = bus.in_valid && bus.in_ready;
        out_fire   = bus.out_valid && bus.out_ready;
        first_elem = (idx_reg == '0);
        cur_any    = first_elem ? 1'b0 : any_nz_reg;
        take_max   = in_nz && (!cur_any || (in_e > max_reg));
        blk_max    = take_max ? in_e : max_reg;
        blk_any    = cur_any || in_nz;
        if (!blk_any || blk_max < 0)
            shared_calc = 8'd0;
        else if (blk_max > 10'sd255)
            shared_calc = 8'd255;
        else
            shared_calc = blk_max[7:0];
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        rd_addr    = '0;
        case (state_reg)
            FILL: begin
                if (in_fire) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = EMIT;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            EMIT: begin
                rd_addr = idx_reg;
                if (out_fire) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = FILL;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                        rd_addr  = idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= FILL;
            idx_reg     <= '0;
            alive_reg   <= 1'b0;
            prec_reg    <= 2'd0;
            max_reg     <= '0;
            any_nz_reg  <= 1'b0;
            shared_reg  <= 8'd0;
            rd_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            alive_reg   <= 1'b1;
            rd_data_reg <= mem[rd_addr];
            if (in_fire) begin
                max_reg    <= blk_max;
                any_nz_reg <= blk_any;
                if (first_elem) prec_reg <= bus.prec_mode;
                if (idx_reg == LAST_IDX) shared_reg <= shared_calc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_fire) mem[idx_reg] <= {in_nz, bus.in_sign, in_e, in_nm};
    end

    // Encode the element currently held in the read register against the shared exponent.
    logic                    rd_nz, rd_sign;
    logic signed [9:0]       rd_e;
    logic [M_IN_WIDTH-1:0]   rd_nm;
    logic [3:0]              w_minus2;
    logic [6:0]              max_mag;
    logic signed [11:0]      sh;
    logic [M_IN_WIDTH:0]     q_r;
    logic [6:0]              mag;
    logic [7:0]              mag8, elem;
`ifdef MX_QUANT_RNE_EN
    logic [2*M_IN_WIDTH-1:0] wide;
    logic                    round_bit, sticky;
`endif

    always_comb begin
        {rd_nz, rd_sign, rd_e, rd_nm} = rd_data_reg;
        case (prec_reg)
            2'd1:    begin w_minus2 = 4'd2; max_mag = 7'd7;   end
            2'd2:    begin w_minus2 = 4'd0; max_mag = 7'd1;   end
            default: begin w_minus2 = 4'd6; max_mag = 7'd127; end
        endcase
        sh = $signed({4'b0000, shared_reg}) - $signed({{2{rd_e[9]}}, rd_e})
           + $signed(12'(M_IN_WIDTH - 1)) - $signed({8'b0, w_minus2});
`ifdef MX_QUANT_RNE_EN
        wide      = {rd_nm, {M_IN_WIDTH{1'b0}}} >> $unsigned(sh);
        round_bit = wide[M_IN_WIDTH-1];
        sticky    = |wide[M_IN_WIDTH-2:0];
        q_r       = {1'b0, wide[2*M_IN_WIDTH-1:M_IN_WIDTH]}
                  + (M_IN_WIDTH+1)'(round_bit && (sticky || wide[M_IN_WIDTH]));
`else
        q_r       = {1'b0, rd_nm >> $unsigned(sh)};
`endif
        if (sh > $signed(12'(M_IN_WIDTH)))
            mag = 7'd0;
        else if (q_r > (M_IN_WIDTH+1)'(max_mag))
            mag = max_mag;
        else
            mag = q_r[6:0];
        mag8 = {1'b0, mag};
        if (!rd_nz)
            elem = 8'd0;
        else
            elem = rd_sign ? -mag8 : mag8;
    end

    assign bus.in_ready       = (state_reg == FILL) && alive_reg;
    assign bus.out_valid      = (state_reg == EMIT);
    assign bus.out_elem       = (state_reg == EMIT) ? elem : 8'd0;
    assign bus.out_idx        = (state_reg == EMIT) ? idx_reg : '0;
    assign bus.out_last       = (state_reg == EMIT) && (idx_reg == LAST_IDX);
    assign bus.out_shared_exp = shared_reg;
endmodule

// File: tb/tb_mx_block_quantizer.sv
// Directed bench for mx_block_quantizer: expected elements are queued at issue, a monitor checks them.
module tb_mx_block_quantizer;
    localparam int M  = 23;
    localparam int BS = 4;

`ifdef MX_QUANT_RNE_EN
    localparam logic [7:0] T2_E0 = 8'h06;
`else
    localparam logic [7:0] T2_E0 = 8'h05;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mx_block_quantizer_if #(.M_IN_WIDTH(M), .BLOCK_SIZE(BS)) bus ();

    mx_block_quantizer #(.M_IN_WIDTH(M), .BLOCK_SIZE(BS)) dut (
        .clk_i (clk),
        .rstn  (rstn),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] elem;
        logic [7:0] shared;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   passes   = 0;
    int   hs_count = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endfunction

    // Monitor: every accepted output element is checked against the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            exp_t act;
            act = {bus.out_elem, bus.out_shared_exp, bus.out_idx, bus.out_last};
            $display("out idx=%0d elem=0x%02h shared=%0d last=%0b",
                     bus.out_idx, bus.out_elem, bus.out_shared_exp, bus.out_last);
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(act), 32'h7FFFFFFF);
            end else begin
                exp_t req;
                req = sb.pop_front();
                check("elem_shared_idx_last", 32'(act), 32'(req));
            end
            hs_count++;
        end
    end

    task automatic push_exp(input logic [7:0] shared, input logic [31:0] ev);
        for (int i = 0; i < BS; i++) begin
            exp_t x;
            x.elem   = ev[8*(3-i) +: 8];
            x.shared = shared;
            x.idx    = 2'(i);
            x.last   = (i == BS - 1);
            sb.push_back(x);
        end
    endtask

    task automatic send_elem(input logic [M-1:0] mant, input logic [7:0] ex,
                             input logic sg, input logic [1:0] pm);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_mant   = mant;
        bus.in_exp    = ex;
        bus.in_sign   = sg;
        bus.prec_mode = pm;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),       32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid),      32'd0);
        check({tag, "_out_elem"},  32'(bus.out_elem),       32'd0);
        check({tag, "_out_shexp"}, 32'(bus.out_shared_exp), 32'd0);
        check({tag, "_out_idx"},   32'(bus.out_idx),        32'd0);
        check({tag, "_out_last"},  32'(bus.out_last),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_exp    = 8'd0;
        bus.in_sign   = 1'b0;
        bus.prec_mode = 2'd0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        // Mixed signs, one zero element, 8-bit
        push_exp(8'd127, {8'h40, 8'hE0, 8'h00, 8'h60});
        send_elem(23'h400000, 8'd127, 1'b0, 2'd0);
        send_elem(23'h400000, 8'd126, 1'b1, 2'd0);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd0);
        send_elem(23'h600000, 8'd127, 1'b0, 2'd0);
        drain();

        // 4-bit ties: rounding mode dependent
        push_exp(8'd127, {T2_E0, 8'h04, 8'h00, 8'h00});
        send_elem(23'h580000, 8'd127, 1'b0, 2'd1);
        send_elem(23'h480000, 8'd127, 1'b0, 2'd1);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd1);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd1);
        drain();

        // Saturation / truncation at the top of the 8-bit range
        push_exp(8'd127, {8'h7F, 8'h00, 8'h00, 8'h00});
        send_elem(23'h7FFFFF, 8'd127, 1'b0, 2'd0);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd0);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd0);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd0);
        drain();

        // Unnormalised mantissa; zero elements with large exponents must not win the max
        push_exp(8'd128, {8'h40, 8'h00, 8'h00, 8'h00});
        send_elem(23'h100000, 8'd130, 1'b0, 2'd0);
        send_elem(23'h000000, 8'd200, 1'b0, 2'd0);
        send_elem(23'h000000, 8'd250, 1'b1, 2'd0);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd0);
        drain();

        // All-zero block
        push_exp(8'd0, 32'h0);
        send_elem(23'h000000, 8'd200, 1'b0, 2'd0);
        send_elem(23'h000000, 8'd127, 1'b1, 2'd0);
        send_elem(23'h000000, 8'd5,   1'b0, 2'd0);
        send_elem(23'h000000, 8'd255, 1'b0, 2'd0);
        drain();

        // 2-bit, prec sampled from the first element only; underflow to 0
        push_exp(8'd127, {8'hFF, 8'h01, 8'h00, 8'hFF});
        send_elem(23'h400000, 8'd127, 1'b1, 2'd2);
        send_elem(23'h600000, 8'd127, 1'b0, 2'd0);
        send_elem(23'h400000, 8'd120, 1'b0, 2'd0);
        send_elem(23'h700000, 8'd127, 1'b1, 2'd0);
        drain();

        // Backpressure at idx 1 (prec 3 acts as 8-bit), with stray input during EMIT
        bus.out_ready = 1'b0;
        push_exp(8'd127, {8'h40, 8'hE0, 8'h00, 8'h60});
        send_elem(23'h400000, 8'd127, 1'b0, 2'd3);
        send_elem(23'h400000, 8'd126, 1'b1, 2'd3);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd3);
        send_elem(23'h600000, 8'd127, 1'b0, 2'd3);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mant   = 23'h7FFFFF;
        bus.in_exp    = 8'd250;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_out_idx",   32'(bus.out_idx),   32'd1);
            check("bp_out_elem",  32'(bus.out_elem),  32'hE0);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset after two emitted elements
        push_exp(8'd127, {8'h40, 8'hE0, 8'h00, 8'h60});
        base = hs_count;
        send_elem(23'h400000, 8'd127, 1'b0, 2'd0);
        send_elem(23'h400000, 8'd126, 1'b1, 2'd0);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd0);
        send_elem(23'h600000, 8'd127, 1'b0, 2'd0);
        n = 0;
        while (hs_count < base + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("emit_timeout", 32'(hs_count - base), 32'd2);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        sb.delete();
        #1;
        check_idle_outputs("midreset");
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_midreset", 32'(bus.in_ready), 32'd1);
        push_exp(8'd128, {8'h40, 8'h00, 8'h00, 8'h00});
        send_elem(23'h100000, 8'd130, 1'b0, 2'd0);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd0);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd0);
        send_elem(23'h000000, 8'd0,   1'b0, 2'd0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
